car_drive_ctrl: RTL and testbench

// - Motion sequencer for the line-following car. Sits between the sensor blocks (tracker_sensor

---
 rtl/car_pkg.sv | 70 +++++++
 rtl/car_dwell_timer.sv | 36 +++
 rtl/car_drive_ctrl.sv | 148 ++++++++++++++
 tb/tb_car_drive_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/car_pkg.sv
// Shared types and codes for the line-following car: FSM states, tracker codes,
// wheel direction codes, motor modes and the registered drive-output bundle.
package car_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FOLLOW = 3'd1,
        ST_TURN_L = 3'd2,
        ST_TURN_R = 3'd3,
        ST_SEARCH = 3'd4,
        ST_OBST   = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef enum logic {
        SIDE_L = 1'b0,
        SIDE_R = 1'b1
    } side_e;

    localparam logic [1:0] TRK_LEFT     = 2'b00;
    localparam logic [1:0] TRK_RIGHT    = 2'b01;
    localparam logic [1:0] TRK_STRAIGHT = 2'b10;
    localparam logic [1:0] TRK_LOST     = 2'b11;

    localparam logic [1:0] DIR_FWD  = 2'b10;
    localparam logic [1:0] DIR_REV  = 2'b01;
    localparam logic [1:0] DIR_STOP = 2'b00;

    localparam logic [2:0] MODE_OFF  = 3'd0;
    localparam logic [2:0] MODE_SLOW = 3'd1;
    localparam logic [2:0] MODE_MED  = 3'd2;
    localparam logic [2:0] MODE_FAST = 3'd3;

    typedef struct packed {
        logic [1:0] left;
        logic [1:0] right;
        logic [2:0] mode;
        logic       halted;
    } drive_t;

    // Wheel/motor pattern for a state; SEARCH spins toward the last turn taken.
    function automatic drive_t decode_drive(input state_e st, input side_e side);
        drive_t d;
        d = '{left: DIR_STOP, right: DIR_STOP, mode: MODE_OFF, halted: 1'b0};
        case (st)
            ST_FOLLOW: begin
                d.left  = DIR_FWD;
                d.right = DIR_FWD;
                d.mode  = MODE_FAST;
            end
            ST_TURN_L: begin
                d.right = DIR_FWD;
                d.mode  = MODE_SLOW;
            end
            ST_TURN_R: begin
                d.left = DIR_FWD;
                d.mode = MODE_SLOW;
            end
            ST_SEARCH: begin
                d.left  = (side == SIDE_L) ? DIR_REV : DIR_FWD;
                d.right = (side == SIDE_L) ? DIR_FWD : DIR_REV;
                d.mode  = MODE_SLOW;
            end
            ST_HALT: d.halted = 1'b1;
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/car_dwell_timer.sv
// Saturating dwell/timeout counter shared by the turn, search and obstacle states.
// 'reached' is high once the count has arrived at (or saturated past) the limit.
module car_dwell_timer #(
    parameter int CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic             reached
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != '1))
            cnt_d = cnt_q + ONE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign reached = (cnt_q >= limit);

endmodule

// File: rtl/car_drive_ctrl.sv
// Motion sequencer for the line-following car: registered FSM with turn dwell,
// lost-line search, obstacle hold/resume and search-timeout halt.
module car_drive_ctrl
    import car_pkg::*;
#(
    parameter int CNT_W      = 27,
    parameter int TURN_MIN   = 50_000,
    parameter int SEARCH_MAX = 100_000_000,
    parameter int RESUME_DLY = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       stop,
    input  logic [1:0] track,
    output logic [1:0] left,
    output logic [1:0] right,
    output logic [2:0] mode,
    output logic [2:0] fsm_state,
    output logic       halted
);

    localparam longint CNT_SPAN = longint'(1) << CNT_W;

    if (TURN_MIN < 1 || longint'(TURN_MIN) >= CNT_SPAN ||
        SEARCH_MAX < 1 || longint'(SEARCH_MAX) >= CNT_SPAN ||
        RESUME_DLY < 1 || longint'(RESUME_DLY) >= CNT_SPAN) begin : g_bad_params
        $error("car_drive_ctrl: timing parameters must be in 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] TURN_LIM   = CNT_W'(TURN_MIN - 1);
    localparam logic [CNT_W-1:0] SEARCH_LIM = CNT_W'(SEARCH_MAX - 1);
    localparam logic [CNT_W-1:0] RESUME_LIM = CNT_W'(RESUME_DLY - 1);

    state_e           state_q, state_d;
    side_e            side_q, side_d;
    drive_t           drv_q, drv_d;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_reached;
    logic [CNT_W-1:0] cnt_limit;

    always_comb begin
        case (state_q)
            ST_SEARCH: cnt_limit = SEARCH_LIM;
            ST_OBST:   cnt_limit = RESUME_LIM;
            default:   cnt_limit = TURN_LIM;
        endcase
    end

    // Priority: !enable, then stop (only in moving states), then per-state rules.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (stop && (state_q inside {ST_FOLLOW, ST_TURN_L, ST_TURN_R, ST_SEARCH})) begin
            state_d = ST_OBST;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_FOLLOW;
                ST_FOLLOW: begin
                    case (track)
                        TRK_LEFT:  state_d = ST_TURN_L;
                        TRK_RIGHT: state_d = ST_TURN_R;
                        TRK_LOST:  state_d = ST_SEARCH;
                        default:   state_d = ST_FOLLOW;
                    endcase
                end
                ST_TURN_L: begin
                    if (cnt_reached) begin
                        case (track)
                            TRK_STRAIGHT: state_d = ST_FOLLOW;
                            TRK_RIGHT:    state_d = ST_TURN_R;
                            TRK_LOST:     state_d = ST_SEARCH;
                            default:      state_d = ST_TURN_L;
                        endcase
                    end
                end
                ST_TURN_R: begin
                    if (cnt_reached) begin
                        case (track)
                            TRK_STRAIGHT: state_d = ST_FOLLOW;
                            TRK_LEFT:     state_d = ST_TURN_L;
                            TRK_LOST:     state_d = ST_SEARCH;
                            default:      state_d = ST_TURN_R;
                        endcase
                    end
                end
                ST_SEARCH: begin
                    if (track != TRK_LOST)
                        state_d = ST_FOLLOW;
                    else if (cnt_reached)
                        state_d = ST_HALT;
                end
                ST_OBST: begin
                    if (!stop && cnt_reached)
                        state_d = ST_FOLLOW;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        side_d = side_q;
        if (state_d == ST_TURN_L)
            side_d = SIDE_L;
        else if (state_d == ST_TURN_R)
            side_d = SIDE_R;
    end

    // Every state change restarts the dwell count; a present obstacle restarts the resume window.
    always_comb begin
        cnt_clr = (state_d != state_q) || ((state_q == ST_OBST) && stop);
        cnt_inc = state_q inside {ST_TURN_L, ST_TURN_R, ST_SEARCH, ST_OBST};
        drv_d   = decode_drive(state_d, side_d);
    end

    car_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .limit   (cnt_limit),
        .reached (cnt_reached)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            side_q  <= SIDE_L;
            drv_q   <= '{left: DIR_STOP, right: DIR_STOP, mode: MODE_OFF, halted: 1'b0};
        end else begin
            state_q <= state_d;
            side_q  <= side_d;
            drv_q   <= drv_d;
        end
    end

    assign left      = drv_q.left;
    assign right     = drv_q.right;
    assign mode      = drv_q.mode;
    assign halted    = drv_q.halted;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_car_drive_ctrl.sv
// Directed-vector bench for car_drive_ctrl with shortened timing parameters
// (TURN_MIN=4, SEARCH_MAX=16, RESUME_DLY=8, CNT_W=8).
module tb_car_drive_ctrl;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       stop;
    logic [1:0] track;
    logic [1:0] left;
    logic [1:0] right;
    logic [2:0] mode;
    logic [2:0] fsm_state;
    logic       halted;

    int vectors;
    int miscompares;

    car_drive_ctrl #(
        .CNT_W      (8),
        .TURN_MIN   (4),
        .SEARCH_MAX (16),
        .RESUME_DLY (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .stop      (stop),
        .track     (track),
        .left      (left),
        .right     (right),
        .mode      (mode),
        .fsm_state (fsm_state),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 ns after the active edge.
    task automatic applyStimulus(input logic r, input logic en, input logic st, input logic [1:0] trk);
        rst    = r;
        enable = en;
        stop   = st;
        track  = trk;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkDrive(input string tag, input logic [2:0] st, input logic [1:0] l,
                              input logic [1:0] r, input logic [2:0] m, input logic h);
        checkOutput({tag, "/state"},  8'(fsm_state), 8'(st));
        checkOutput({tag, "/left"},   8'(left),      8'(l));
        checkOutput({tag, "/right"},  8'(right),     8'(r));
        checkOutput({tag, "/mode"},   8'(mode),      8'(m));
        checkOutput({tag, "/halted"}, 8'(halted),    8'(h));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1; enable = 1'b0; stop = 1'b0; track = 2'b10;

        applyStimulus(1, 0, 0, 2'b10);
        applyStimulus(1, 1, 0, 2'b10);
        checkDrive("reset", 3'd0, 2'b00, 2'b00, 3'd0, 1'b0);

        applyStimulus(0, 1, 0, 2'b10);
        checkDrive("idle_to_follow", 3'd1, 2'b10, 2'b10, 3'd3, 1'b0);
        applyStimulus(0, 1, 0, 2'b10);
        checkOutput("follow_hold", 8'(fsm_state), 8'd1);

        applyStimulus(0, 1, 0, 2'b00);
        checkDrive("turn_l_enter", 3'd2, 2'b00, 2'b10, 3'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 2'b10);
            checkOutput($sformatf("turn_l_dwell%0d", i), 8'(fsm_state), 8'd2);
        end
        applyStimulus(0, 1, 0, 2'b10);
        checkDrive("turn_l_exit", 3'd1, 2'b10, 2'b10, 3'd3, 1'b0);

        applyStimulus(0, 1, 0, 2'b01);
        checkDrive("turn_r_enter", 3'd3, 2'b10, 2'b00, 3'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 2'b01);
            checkOutput($sformatf("turn_r_dwell%0d", i), 8'(fsm_state), 8'd3);
        end
        applyStimulus(0, 1, 0, 2'b11);
        checkDrive("search_r_enter", 3'd4, 2'b10, 2'b01, 3'd1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, 1, 0, 2'b11);
            checkOutput($sformatf("search_hold%0d", i), 8'(fsm_state), 8'd4);
        end
        applyStimulus(0, 1, 0, 2'b11);
        checkDrive("search_timeout", 3'd6, 2'b00, 2'b00, 3'd0, 1'b1);
        applyStimulus(0, 1, 1, 2'b10);
        checkOutput("halt_ignores_stop", 8'(fsm_state), 8'd6);
        applyStimulus(0, 0, 0, 2'b10);
        checkDrive("halt_to_idle", 3'd0, 2'b00, 2'b00, 3'd0, 1'b0);
        applyStimulus(0, 1, 0, 2'b10);
        checkOutput("idle_to_follow2", 8'(fsm_state), 8'd1);

        applyStimulus(0, 1, 0, 2'b00);
        checkOutput("turn_l_again", 8'(fsm_state), 8'd2);
        applyStimulus(0, 1, 1, 2'b00);
        checkDrive("obst_enter", 3'd5, 2'b00, 2'b00, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 2'b10);
            checkOutput($sformatf("obst_low_a%0d", i), 8'(fsm_state), 8'd5);
        end
        applyStimulus(0, 1, 1, 2'b10);
        checkOutput("obst_restart", 8'(fsm_state), 8'd5);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 1, 0, 2'b10);
            checkOutput($sformatf("obst_low_b%0d", i), 8'(fsm_state), 8'd5);
        end
        applyStimulus(0, 1, 0, 2'b10);
        checkDrive("obst_resume", 3'd1, 2'b10, 2'b10, 3'd3, 1'b0);

        applyStimulus(0, 1, 0, 2'b11);
        checkDrive("search_l_enter", 3'd4, 2'b01, 2'b10, 3'd1, 1'b0);
        for (int i = 0; i < 15; i++)
            applyStimulus(0, 1, 0, 2'b11);
        checkOutput("search_pre_timeout", 8'(fsm_state), 8'd4);
        applyStimulus(0, 1, 0, 2'b01);
        checkDrive("reacquire_on_timeout", 3'd1, 2'b10, 2'b10, 3'd3, 1'b0);
        applyStimulus(0, 0, 1, 2'b10);
        checkDrive("disable_beats_stop", 3'd0, 2'b00, 2'b00, 3'd0, 1'b0);

        applyStimulus(0, 1, 0, 2'b10);
        applyStimulus(0, 1, 0, 2'b01);
        checkOutput("turn_r_again", 8'(fsm_state), 8'd3);
        applyStimulus(0, 1, 0, 2'b01);
        applyStimulus(1, 1, 0, 2'b01);
        checkDrive("reset_mid_turn", 3'd0, 2'b00, 2'b00, 3'd0, 1'b0);
        applyStimulus(0, 1, 0, 2'b10);
        checkOutput("post_reset_follow", 8'(fsm_state), 8'd1);
        applyStimulus(0, 1, 0, 2'b11);
        checkDrive("post_reset_side_l", 3'd4, 2'b01, 2'b10, 3'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
